// File: rtl/wb_rr_arbiter_2m.sv
// Two-master round-robin arbiter for a pipelined Wishbone bus.
// Ports: clk/rst, master ports m0_*/m1_*, shared slave-side port s_*.
module wb_rr_arbiter_2m #(
    parameter int AW              = 30,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_w,
    output logic [DW-1:0]   m0_dat_r,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_sel,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    output logic            m0_stall,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_w,
    output logic [DW-1:0]   m1_dat_r,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_sel,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    output logic            m1_stall,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic            s_we,
    output logic [DW/8-1:0] s_sel,
    output logic            s_cyc,
    output logic            s_stb,
    input  logic [DW-1:0]   s_dat_r,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic            s_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_CNT = MAX_OUTSTANDING[3:0];

    owner_t     owner, owner_nxt;
    owner_t     last, last_nxt;
    logic [3:0] cnt, cnt_nxt, cnt_upd;
    logic       full, inc, done;

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    assign full = (cnt == MAX_CNT);
    assign inc  = s_stb && !s_stall;
    assign done = s_ack || s_err;

    // Simultaneous accept and completion cancel out; a completion
    // with nothing outstanding is forwarded but never underflows.
    always_comb begin
        cnt_upd = cnt;
        if (inc && !done)
            cnt_upd = cnt + 4'd1;
        else if (!inc && done && cnt != 4'd0)
            cnt_upd = cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= IDLE;
            last  <= M1;
            cnt   <= 4'd0;
        end else begin
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        s_adr     = '0;
        s_dat_w   = '0;
        s_we      = 1'b0;
        s_sel     = '0;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        m0_stall  = 1'b1;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_stall  = 1'b1;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        unique case (owner)
            IDLE: begin
                // Late completions are dropped here; count restarts at 0.
                cnt_nxt = 4'd0;
                if (m0_cyc && (!m1_cyc || last == M1)) begin
                    owner_nxt = M0;
                    last_nxt  = M0;
                end else if (m1_cyc) begin
                    owner_nxt = M1;
                    last_nxt  = M1;
                end
            end
            M0: begin
                s_adr    = m0_adr;
                s_dat_w  = m0_dat_w;
                s_we     = m0_we;
                s_sel    = m0_sel;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb && !full;
                m0_stall = s_stall || full;
                m0_ack   = s_ack;
                m0_err   = s_err;
                if (!m0_cyc) begin
                    owner_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt_upd;
                end
            end
            M1: begin
                s_adr    = m1_adr;
                s_dat_w  = m1_dat_w;
                s_we     = m1_we;
                s_sel    = m1_sel;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb && !full;
                m1_stall = s_stall || full;
                m1_ack   = s_ack;
                m1_err   = s_err;
                if (!m1_cyc) begin
                    owner_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt_upd;
                end
            end
            default: begin
                owner_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter_2m.sv
// Directed bench for wb_rr_arbiter_2m.
// Ports: none (drives and checks the arbiter).
module tb_wb_rr_arbiter_2m;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] m0_adr, m1_adr, s_adr;
    logic [31:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
    logic [31:0] s_dat_w, s_dat_r;
    logic        m0_we, m1_we, s_we;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic        m0_cyc, m0_stb, m0_stall, m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_stall, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_ack, s_err, s_stall;

    int errors = 0;
    int checks = 0;
    int idx;
    int acc;
    logic [29:0] acc_adr [$];

    always #5 clk = ~clk;

    wb_rr_arbiter_2m dut (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_we(m0_we), .m0_sel(m0_sel), .m0_cyc(m0_cyc),
        .m0_stb(m0_stb), .m0_stall(m0_stall), .m0_ack(m0_ack),
        .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_we(m1_we), .m1_sel(m1_sel), .m1_cyc(m1_cyc),
        .m1_stb(m1_stb), .m1_stall(m1_stall), .m1_ack(m1_ack),
        .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_we(s_we), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_adr = '0; m0_dat_w = '0; m0_we = 0; m0_sel = '0;
        m0_cyc = 0; m0_stb = 0;
        m1_adr = '0; m1_dat_w = '0; m1_we = 0; m1_sel = '0;
        m1_cyc = 0; m1_stb = 0;
        s_dat_r = '0; s_ack = 0; s_err = 0; s_stall = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        #1;
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_stalls", {30'd0, m1_stall, m0_stall}, 3);
        chk("rst_s_adr", 32'(s_adr), 0);
        chk("rst_cnt", 32'(dut.cnt), 0);

        // Single master, 3 pipelined reads, acks one cycle later
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h100; m0_sel = 4'hf;
        #1;
        chk("t1_grant_stall", 32'(m0_stall), 1);
        chk("t1_grant_stb", 32'(s_stb), 0);
        tick();
        #1;
        chk("t1_stb0", 32'(s_stb), 1);
        chk("t1_adr0", 32'(s_adr), 32'h100);
        chk("t1_stall0", 32'(m0_stall), 0);
        tick();
        m0_adr = 30'h101; s_ack = 1; s_dat_r = 32'hA0;
        #1;
        chk("t1_stb1", 32'(s_stb), 1);
        chk("t1_adr1", 32'(s_adr), 32'h101);
        chk("t1_ack0", {m1_ack, m0_ack}, 32'h1);
        chk("t1_dat0", m0_dat_r, 32'hA0);
        tick();
        m0_adr = 30'h102; s_dat_r = 32'hA1;
        #1;
        chk("t1_stb2", 32'(s_stb), 1);
        chk("t1_adr2", 32'(s_adr), 32'h102);
        chk("t1_ack1", {m1_ack, m0_ack}, 32'h1);
        chk("t1_dat1", m0_dat_r, 32'hA1);
        tick();
        m0_stb = 0; s_dat_r = 32'hA2;
        #1;
        chk("t1_stb_off", 32'(s_stb), 0);
        chk("t1_ack2", {m1_ack, m0_ack}, 32'h1);
        chk("t1_dat2", m0_dat_r, 32'hA2);
        tick();
        s_ack = 0; m0_cyc = 0;
        #1;
        chk("t1_cnt_done", 32'(dut.cnt), 0);
        chk("t1_release_cyc", 32'(s_cyc), 0);
        tick();
        chk("t1_idle", 32'(dut.owner), 0);

        // Contention after reset
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h10;
        m1_cyc = 1; m1_stb = 1; m1_adr = 30'h20;
        #1;
        chk("t2_both_stall", {30'd0, m1_stall, m0_stall}, 3);
        tick();
        chk("t2_m0_adr", 32'(s_adr), 32'h10);
        chk("t2_m0_grant", {30'd0, m1_stall, m0_stall}, 2);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack = 1;
        #1;
        chk("t2_m0_ack", {m1_ack, m0_ack}, 32'h1);
        chk("t2_drop_cyc", 32'(s_cyc), 0);
        chk("t2_m1_wait", 32'(m1_stall), 1);
        tick();
        s_ack = 0;
        chk("t2_gap_cyc", 32'(s_cyc), 0);
        chk("t2_gap_stall", 32'(m1_stall), 1);
        tick();
        chk("t2_m1_cyc", 32'(s_cyc), 1);
        chk("t2_m1_adr", 32'(s_adr), 32'h20);
        chk("t2_m1_grant", {30'd0, m1_stall, m0_stall}, 1);
        tick();
        m1_cyc = 0; m1_stb = 0;
        tick();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("t2_alt_adr", 32'(s_adr), 32'h10);
        chk("t2_alt_grant", {30'd0, m1_stall, m0_stall}, 2);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        tick();

        // Outstanding limit: m1 issues writes, slave withholds acks
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 30'h30;
        tick();
        idx = 0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            m1_adr = 30'h30 + 30'(idx);
            #1;
            if (s_stb && !s_stall) acc++;
            if (!m1_stall) idx++;
            tick();
        end
        chk("t3_accepts", 32'(acc), 4);
        chk("t3_cnt_full", 32'(dut.cnt), 4);
        m1_adr = 30'h30 + 30'(idx);
        s_ack = 1;
        #1;
        chk("t3_full_stall", 32'(m1_stall), 1);
        chk("t3_full_stb", 32'(s_stb), 0);
        chk("t3_ack_fwd", {m1_ack, m0_ack}, 32'h2);
        tick();
        s_ack = 0;
        #1;
        chk("t3_5th_stall", 32'(m1_stall), 0);
        chk("t3_5th_stb", 32'(s_stb), 1);
        chk("t3_5th_adr", 32'(s_adr), 32'h34);
        tick();
        chk("t3_refull", 32'(m1_stall), 1);
        m1_cyc = 0; m1_stb = 0;
        tick();

        // Slave stall mid-burst
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h200;
        tick();
        idx = 0;
        acc_adr.delete();
        for (int k = 0; k < 10; k++) begin
            m0_stb  = (idx < 4);
            m0_adr  = 30'h200 + 30'(idx);
            s_stall = (k >= 2 && k <= 4);
            #1;
            if (s_stall) begin
                chk("t4_stall_fwd", 32'(m0_stall), 1);
                chk("t4_adr_hold", 32'(s_adr), 32'h200 + 32'(idx));
            end
            if (s_stb && !s_stall) acc_adr.push_back(s_adr);
            if (m0_stb && !m0_stall) idx++;
            tick();
        end
        s_stall = 0;
        chk("t4_accepts", 32'(acc_adr.size()), 4);
        foreach (acc_adr[i])
            chk("t4_order", 32'(acc_adr[i]), 32'h200 + 32'(i));
        chk("t4_cnt", 32'(dut.cnt), 4);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // Abort with 2 outstanding, then stray acks
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h300;
        tick();
        tick();
        m0_adr = 30'h301;
        tick();
        m0_stb = 0;
        chk("t5_cnt2", 32'(dut.cnt), 2);
        m0_cyc = 0;
        tick();
        chk("t5_idle", 32'(dut.owner), 0);
        chk("t5_cnt0", 32'(dut.cnt), 0);
        s_ack = 1;
        #1;
        chk("t5_stray1", {m1_ack, m0_ack}, 0);
        tick();
        #1;
        chk("t5_stray2", {m1_ack, m0_ack}, 0);
        tick();
        s_ack = 0;
        m1_cyc = 1; m1_stb = 1; m1_adr = 30'h40;
        tick();
        chk("t5_m1_grant", 32'(m1_stall), 0);
        chk("t5_m1_noack", {m1_err, m1_ack}, 0);
        tick();
        chk("t5_m1_noack2", {m1_err, m1_ack}, 0);
        m1_cyc = 0; m1_stb = 0;
        tick();

        // Reset mid-burst with m1 owning and 3 outstanding
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 30'h50;
        tick();
        tick();
        tick();
        tick();
        chk("t6_cnt3", 32'(dut.cnt), 3);
        chk("t6_owner_m1", 32'(dut.owner), 2);
        rst = 1;
        tick();
        rst = 0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h60;
        #1;
        chk("t6_s_cyc", 32'(s_cyc), 0);
        chk("t6_cnt0", 32'(dut.cnt), 0);
        chk("t6_idle", 32'(dut.owner), 0);
        tick();
        chk("t6_m0_wins", {30'd0, m1_stall, m0_stall}, 2);
        chk("t6_m0_adr", 32'(s_adr), 32'h60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
